// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bundle between a core's load/store path
// and the dmem_lsu data memory. The master modport is the requester side,
// the slave modport is the memory side.
interface dmem_lsu_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [DM_ADDRESS+1:0] addr;
  logic [DATA_W-1:0]     wd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rd;
  logic                  err;

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wd, rsp_ready,
    input  req_ready, rsp_valid, rd, err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wd, rsp_ready,
    output req_ready, rsp_valid, rd, err
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory with a valid/ready load/store port.
// Loads respond one cycle after acceptance with size/sign extension; stores
// write on the accepting edge and produce no response. Illegal funct3 yields
// err (with rd=0 on loads). Optional build macro DMEM_MISALIGN_CHECK_EN turns
// misaligned H/W accesses into errors instead of silently aligning them.
module dmem_lsu #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_lsu_if.slave bus
);
  localparam int DEPTH = 2 ** DM_ADDRESS;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rd_q, rd_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DM_ADDRESS-1:0] widx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  is_store;
  logic                  is_load;
  logic                  bad_op;
  logic                  misalign;
  logic                  wr_en;
  logic [LANES-1:0]      be;
  logic [DATA_W-1:0]     wdata;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  endfunction

  // Byte/halfword selection from the addressed word, then sign/zero extend.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   load_extract = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [LANES-1:0] store_be(input logic [2:0] f3, input logic [1:0] ln);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << ln;
      2'b01:   store_be = ln[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [DATA_W-1:0] store_data(input logic [2:0] f3, input logic [DATA_W-1:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  assign widx = bus.addr[DM_ADDRESS+1:2];
  assign lane = bus.addr[1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((bus.funct3[1:0] == 2'b01) && lane[0]) ||
                    ((bus.funct3[1:0] == 2'b10) && (lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Requests presented while reset is asserted are never taken.
  assign accept   = bus.req_valid && bus.req_ready && rst_n;
  assign is_store = bus.mem_write;
  assign is_load  = bus.mem_read && !bus.mem_write;
  assign bad_op   = !f3_legal(bus.funct3) || misalign;
  assign wr_en    = accept && is_store && !bad_op;
  assign be       = store_be(bus.funct3, lane);
  assign wdata    = store_data(bus.funct3, bus.wd);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a new accepted load always keeps or enters RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && is_load) state_d = S_RESP;
      S_RESP: begin
        if (accept && is_load) state_d = S_RESP;
        else if (bus.rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: response flag and combinational backpressure.
  always_comb begin
    rsp_valid     = (state_q == S_RESP);
    bus.rsp_valid = rsp_valid;
    bus.req_ready = !rsp_valid || bus.rsp_ready;
  end

  // Response data/error next value; held while a response is stalled.
  always_comb begin
    rd_d  = rd_q;
    err_d = 1'b0;
    if (accept && is_load) begin
      rd_d  = bad_op ? '0 : load_extract(mem[widx], bus.funct3, lane);
      err_d = bad_op;
    end else if (accept && is_store) begin
      err_d = bad_op;
    end else if (rsp_valid && !bus.rsp_ready) begin
      err_d = err_q;
    end
  end

  // Response data/error registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      err_q <= err_d;
    end
  end

  assign bus.rd  = rd_q;
  assign bus.err = err_q;

  // Storage array with per-byte write enables; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, word-index width; depth = 2**DM_ADDRESS words.
REQ-002 SHALL have parameter DATA_W, default 32, word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port mem_read  input  1  load request (from control unit).
REQ-008 SHALL have port mem_write  input  1  store request (from control unit).
REQ-009 SHALL have port funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port addr  input  DM_ADDRESS+2  byte address (LSBs of ALU result).
REQ-011 SHALL have port wd  input  DATA_W  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  load response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 SHALL have port rd  output  DATA_W  load data, extended per funct3.
REQ-015 SHALL have port err  output  1  response/store error flag, one pulse or held with response.

Function
REQ-016 SHALL hold storage as 2**DM_ADDRESS x DATA_W array with per-byte write enables; word index = addr[DM_ADDRESS+1:2], byte lane = addr[1:0].
REQ-017 SHALL implement FSM IDLE/RESP: IDLE -> RESP on accepted load; RESP -> IDLE on rsp_ready with no new accepted load; RESP -> RESP on rsp_ready with new accepted load.
REQ-018 SHALL drive req_ready = !rsp_valid || rsp_ready (combinational).
REQ-019 SHALL register load data: rsp_valid and rd asserted the cycle after acceptance (latency 1); rd, err held stable while rsp_valid && !rsp_ready.
REQ-020 SHALL sign-extend B/H and zero-extend BU/HU/upper bits; select byte by addr[1:0], halfword by addr[1].
REQ-021 SHALL write stores on the accepting edge: B writes lane addr[1:0] with wd[7:0]; H writes lanes addr[1]*2+{0,1} with wd[15:0]; W writes all lanes; other lanes unchanged.
REQ-022 SHALL produce no response for stores; req_ready for stores follows REQ-018 unchanged.
REQ-023 SHALL treat mem_read && mem_write together as a store (write priority), no response.
REQ-024 SHALL treat illegal funct3 (011, 110, 111): load -> response with rd=0, err=1; store -> no write, err pulses 1 cycle.
REQ-025 SHALL return newly written data for a load accepted the cycle after a store to the same word (read-after-write, no stale data).
REQ-026 SHALL drive err=0 whenever neither a response nor a store error is present.
REQ-027 SHALL ignore requests with req_valid low regardless of mem_read/mem_write.

Reset
REQ-028 SHALL on rst_n low immediately force rsp_valid=0, rd=0, err=0, FSM=IDLE.
REQ-029 SHALL discard any pending response on reset mid-operation; no memory contents reset.
REQ-030 SHALL ignore requests while rst_n low; first acceptance possible on first edge after release.

Configuration
REQ-031 SHALL honour macro DMEM_MISALIGN_CHECK_EN.
REQ-032 SHALL with DMEM_MISALIGN_CHECK_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> load responds rd=0, err=1; store suppressed, err pulses 1 cycle.
REQ-033 SHALL without DMEM_MISALIGN_CHECK_EN: misaligned low bits ignored (H uses addr[1], W uses addr[1:0]=00), err never set by alignment.

Verification
REQ-034 SHALL cover: SW 0x8000_00F1 @0x010, then LB @0x010 -> rd=0xFFFF_FFF1, LBU -> 0x0000_00F1, rsp_valid one cycle after acceptance.
REQ-035 SHALL cover: SW 0x1122_3344 @0x020, SB 0xAA @0x022, LW @0x020 -> 0x11AA_3344.
REQ-036 SHALL cover: load accepted, rsp_ready low 3 cycles -> req_ready=0, rd/rsp_valid stable; rsp_ready high -> back-to-back load accepted same cycle.
REQ-037 SHALL cover: LH @0x031 -> with macro rd=0, err=1; without macro rd = halfword @0x030 extended, err=0.
REQ-038 SHALL cover: rst_n low while rsp_valid=1 -> rsp_valid, rd, err drop to 0 asynchronously; prior SW data still readable after release.
REQ-039 SHALL cover: funct3=011 load -> err=1, rd=0; funct3=111 store -> memory unchanged, err one-cycle pulse.
